// File: rtl/frame_stack_if.sv
// Push/pop strobes, push data and stack status
// shared by the recursion controller and frame_stack.
interface frame_stack_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
);
  logic             push;
  logic             pop;
  logic [1:0]       pushSrc;
  logic [WIDTH-1:0] nIn;
  logic [WIDTH-1:0] resIn;
  logic             flagIn;
  logic [WIDTH-1:0] dataOut;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  logic [AW:0]      peak;

  modport master (
    output push, pop, pushSrc,
    output nIn, resIn, flagIn,
    input  dataOut, empty, full, count,
    input  overflow, underflow, peak
  );

  modport slave (
    input  push, pop, pushSrc,
    input  nIn, resIn, flagIn,
    output dataOut, empty, full, count,
    output overflow, underflow, peak
  );
endinterface

// File: rtl/frame_stack.sv
// LIFO word stack for recursion frames with
// zero-latency top read and sticky debug status.
module frame_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 48,
  parameter int AW    = 6
) (
  input logic         clk,
  input logic         rst,
  frame_stack_if.slave bus
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      cnt, cntNext, pk;
  logic             ovf, unf, ovfSet, unfSet;
  logic             wrEn, isEmpty, isFull;
  logic [AW-1:0]    wrIdx, topIdx;
  logic [WIDTH-1:0] word;

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == (AW+1)'(DEPTH));
  assign topIdx  = AW'(cnt - 1'b1);

  always_comb begin
    word = '0;
    unique case (bus.pushSrc)
      2'd0: word = {{(WIDTH-1){1'b0}}, bus.flagIn};
      2'd1: word = bus.nIn;
      2'd2: word = bus.resIn;
      default: word = '0;
    endcase
  end

  always_comb begin
    cntNext = cnt;
    wrEn    = 1'b0;
    wrIdx   = AW'(cnt);
    ovfSet  = 1'b0;
    unfSet  = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (isFull) ovfSet = 1'b1;
        else begin
          wrEn    = 1'b1;
          cntNext = cnt + 1'b1;
        end
      end
      2'b01: begin
        if (isEmpty) unfSet = 1'b1;
        else cntNext = cnt - 1'b1;
      end
      2'b11: begin
        // simultaneous push/pop on an empty stack is a plain push
        wrEn = 1'b1;
        if (isEmpty) cntNext = cnt + 1'b1;
        else wrIdx = topIdx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wrEn && !rst) mem[wrIdx] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pk  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cntNext;
      if (cntNext > pk) pk <= cntNext;
      if (ovfSet) ovf <= 1'b1;
      if (unfSet) unf <= 1'b1;
    end
  end

  assign bus.dataOut   = isEmpty ? '0 : mem[topIdx];
  assign bus.empty     = isEmpty;
  assign bus.full      = isFull;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
  assign bus.peak      = pk;
endmodule

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack: queue-based model
// checked every cycle plus literal spot checks.
module tb_frame_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   checkEn = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  frame_stack_if #(.WIDTH(16), .AW(6)) bus ();

  frame_stack #(.WIDTH(16), .DEPTH(48), .AW(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] q[$];
  bit          mOvf = 1'b0;
  bit          mUnf = 1'b0;
  int          mPeak = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] selWord();
    case (bus.pushSrc)
      2'd0: return {15'd0, bus.flagIn};
      2'd1: return bus.nIn;
      2'd2: return bus.resIn;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [15:0] w;
    w = selWord();
    if (rst) begin
      q.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
      mPeak = 0;
    end else begin
      if (bus.push && bus.pop && q.size() > 0)
        q[q.size()-1] = w;
      else if (bus.push) begin
        if (q.size() == 48) mOvf = 1'b1;
        else q.push_back(w);
      end else if (bus.pop) begin
        if (q.size() == 0) mUnf = 1'b1;
        else void'(q.pop_back());
      end
      if (q.size() > mPeak) mPeak = q.size();
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      logic [15:0] top;
      top = (q.size() == 0) ? 16'd0 : q[q.size()-1];
      chk("dataOut", 32'(bus.dataOut), 32'(top));
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("full", 32'(bus.full), 32'(q.size() == 48));
      chk("overflow", 32'(bus.overflow), 32'(mOvf));
      chk("underflow", 32'(bus.underflow), 32'(mUnf));
      chk("peak", 32'(bus.peak), 32'(mPeak));
    end
  end

  task automatic cyc(input bit p, input bit o,
                     input logic [1:0] s,
                     input logic [15:0] n,
                     input logic [15:0] r,
                     input bit f);
    bus.push    = p;
    bus.pop     = o;
    bus.pushSrc = s;
    bus.nIn     = n;
    bus.resIn   = r;
    bus.flagIn  = f;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic reset1();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.pushSrc = 0;
    bus.nIn = 0; bus.resIn = 0; bus.flagIn = 0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checkEn = 1'b1;
    chk("rst empty", 32'(bus.empty), 1);
    chk("rst dataOut", 32'(bus.dataOut), 0);
    chk("rst peak", 32'(bus.peak), 0);

    cyc(1, 0, 1, 5, 0, 0);
    cyc(1, 0, 2, 0, 8, 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t1 count", 32'(bus.count), 3);
    chk("t1 top flag", 32'(bus.dataOut), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t1 pop1 top", 32'(bus.dataOut), 8);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t1 pop2 top", 32'(bus.dataOut), 5);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t1 empty", 32'(bus.empty), 1);
    chk("t1 dataOut", 32'(bus.dataOut), 0);

    cyc(0, 1, 0, 0, 0, 0);
    chk("t2 underflow", 32'(bus.underflow), 1);
    chk("t2 count", 32'(bus.count), 0);
    cyc(1, 0, 1, 3, 0, 0);
    chk("t2 push after", 32'(bus.dataOut), 3);
    chk("t2 sticky", 32'(bus.underflow), 1);
    cyc(0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 48; i++)
      cyc(1, 0, 1, 16'(i), 0, 0);
    chk("t3 full", 32'(bus.full), 1);
    chk("t3 peak", 32'(bus.peak), 48);
    chk("t3 no ovf yet", 32'(bus.overflow), 0);
    cyc(1, 0, 1, 99, 0, 0);
    chk("t3 overflow", 32'(bus.overflow), 1);
    chk("t3 top kept", 32'(bus.dataOut), 47);
    chk("t3 count", 32'(bus.count), 48);

    reset1();
    cyc(1, 0, 1, 3, 0, 0);
    cyc(1, 0, 1, 7, 0, 0);
    cyc(1, 1, 2, 0, 9, 0);
    chk("t4 repl count", 32'(bus.count), 2);
    chk("t4 repl top", 32'(bus.dataOut), 9);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t4 below", 32'(bus.dataOut), 3);
    reset1();
    cyc(1, 1, 1, 4, 0, 0);
    chk("t4 empty count", 32'(bus.count), 1);
    chk("t4 empty top", 32'(bus.dataOut), 4);
    chk("t4 no unf", 32'(bus.underflow), 0);

    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 1, 2, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 10, 0, 0);
    cyc(1, 0, 1, 11, 0, 0);
    cyc(1, 0, 1, 12, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 1, 13, 0, 0);
    rst = 1'b0;
    chk("t5 count", 32'(bus.count), 0);
    chk("t5 empty", 32'(bus.empty), 1);
    chk("t5 peak", 32'(bus.peak), 0);
    chk("t5 unf", 32'(bus.underflow), 0);
    chk("t5 ovf", 32'(bus.overflow), 0);
    chk("t5 dataOut", 32'(bus.dataOut), 0);

    cyc(1, 0, 3, 16'hFFFF, 16'hFFFF, 1);
    chk("t6 src3", 32'(bus.dataOut), 0);
    chk("t6 count", 32'(bus.count), 1);
    cyc(1, 0, 0, 16'hFFFF, 16'hFFFF, 1);
    chk("t6 flag", 32'(bus.dataOut), 32'h0001);
    cyc(1, 1, 2, 0, 16'h1234, 0);
    chk("t6 repl res", 32'(bus.dataOut), 32'h1234);
    cyc(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
